sci_fifo_readout_arb: RTL and testbench
=======================================

Name: sci_fifo_readout_arb

Overview:
- Round-robin readout scheduler that drains fixed-length science packets from N single-clock byte FIFOs onto one downstream byte stream using valid/ready.
- Typical sources: the trigger sci-data FIFO (20-byte packets) and peer sub-detector FIFOs.
- Each packet is transferred atomically, with SOP/EOP/source tags.
- A starved source is aborted after a timeout.
- Sits between the sci-data FIFOs and the packet framer/uplink.

Parameters:
- N_SRC, 4, number of requesting FIFOs.
- SRC_W, 2, width of source index; equals clog2(N_SRC).
- PKT_LEN, 20, bytes per packet.
- TIMEOUT, 255, max cycles waiting on an empty FIFO mid-packet.

Ports:
- clk_in  input  1  system clock, 50 MHz. Single clock; rst_in is asynchronous and active-high.
- rst_in  input  1  asynchronous active-high reset.
- src_en_in  input  N_SRC  per-source enable mask.
- fifo_empty_in  input  N_SRC  FIFO empty flags.
- fifo_data_in  input  8*N_SRC  FIFO dout; source i occupies bits [8i+7:8i].
- fifo_rd_out  output  N_SRC  FIFO rd_en, one-hot or zero.
- out_data  output  8  byte to downstream.
- out_valid  output  1  out_data valid.
- out_ready_in  input  1  downstream accept.
- out_sop  output  1  high with the first byte of a packet.
- out_eop  output  1  high with the last byte of a packet.
- out_src  output  SRC_W  granted source index.
- pkt_cnt_out  output  16  completed-packet counter; wraps.
- timeout_err_out  output  1  one-cycle pulse on abort.
- busy_out  output  1  high when the state is not IDLE.

Behaviour:
- Reset (asynchronous): state=IDLE, all outputs 0, byte_cnt=0, wait_cnt=0, pkt_cnt=0, last_grant=N_SRC-1, so source 0 wins first.
- FIFO read latency is 1 cycle: dout is valid the cycle after rd_en.
- Eligible source: src_en_in[i] & ~fifo_empty_in[i].
- Round-robin search order: last_grant+1 … last_grant, wrapping modulo N_SRC.
- IDLE: if any source is eligible, latch grant=first eligible in search order, byte_cnt=0 -> READ. Otherwise stay.
- READ:
  - If ~fifo_empty_in[grant]: assert fifo_rd_out[grant] for exactly this cycle, wait_cnt=0 -> CAPTURE.
  - Else wait_cnt++. When wait_cnt==TIMEOUT: pulse timeout_err_out, set last_grant=grant -> IDLE. No EOP is emitted, and pkt_cnt does not change.
- CAPTURE: out_data<=fifo_data_in[grant], out_valid<=1, out_sop<=(byte_cnt==0), out_eop<=(byte_cnt==PKT_LEN-1), out_src<=grant -> SEND.
- SEND: hold out_data, out_valid, out_sop, out_eop and out_src stable until out_ready_in=1. On handshake:
  - out_valid<=0.
  - If byte_cnt==PKT_LEN-1 -> DONE.
  - Else byte_cnt++ -> READ.
- DONE: pkt_cnt++ (16-bit wrap 0xFFFF->0), last_grant=grant -> IDLE.
- Throughput: 3 cycles/byte minimum; 1 idle cycle between packets (DONE) plus 1 cycle arbitration (IDLE).
- out_ready_in asserted while out_valid=0 is ignored.
- Clearing src_en_in for the granted source mid-packet does not abort the packet. The mask is sampled only in IDLE.
- fifo_empty_in toggling during CAPTURE or SEND has no effect.
- fifo_rd_out is never asserted when the addressed empty flag is 1 and is never asserted outside READ.
- Reset mid-packet abandons the packet immediately. No EOP and no counter update occur; any partial bytes remain in the downstream FIFO, and resynchronisation is the downstream's job.
- byte_cnt width: clog2(PKT_LEN). wait_cnt width: clog2(TIMEOUT+1).

Decomposition:
- Package sci_readout_pkg:
  - state enum {IDLE, READ, CAPTURE, SEND, DONE} (3 bits).
  - Default constants PKT_LEN_DEF=20, TIMEOUT_DEF=255.
  - Byte-stream field widths.
- Sub-module rr_arbiter: combinational eligible-vector plus last_grant pointer -> grant index and any_req. Parameterised by N_SRC.
- The top holds the FSM, counters and output register.

Test Plan:
- Single source: src0 FIFO preloaded with 20 bytes 0x00..0x13, out_ready_in=1 -> 20 beats; SOP on 0x00, EOP on 0x13, out_src=0, pkt_cnt_out=1, each byte 3 cycles apart.
- Contention: src0, src1 and src3 each hold 2 packets, all enabled -> packet order 0,1,3,0,1,3; every packet contiguous (out_src constant SOP..EOP).
- Backpressure: out_ready_in low 10 cycles at byte 5 -> out_data/out_valid stable during stall; no extra fifo_rd_out pulses; all bytes in order.
- Underrun: src2 holds only 7 bytes -> after byte 7, TIMEOUT=255 cycles later timeout_err_out pulses once; pkt_cnt unchanged; next grant goes to src3 or a wrapped eligible source.
- Mask: src1 has data but src_en_in[1]=0 -> never granted. Clearing src_en_in[0] mid-packet lets the packet complete.
- Reset mid-packet at byte 10, then release with src0 data present -> outputs 0 during reset; after release src0 granted first; pkt_cnt_out=0 before completion.

Source files
------------

// File: rtl/sci_readout_pkg.sv
// rtl/sci_readout_pkg.sv - shared types and constants for the science FIFO readout arbiter
package sci_readout_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      CAPTURE = 3'd2,
      SEND    = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam int PKT_LEN_DEF = 20;
   localparam int TIMEOUT_DEF = 255;
   localparam int BYTE_W      = 8;
   localparam int PKT_CNT_W   = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting one past the last grant
module rr_arbiter
   import sci_readout_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int SRC_W = 2
) (
   input  logic [N_SRC-1:0] req,
   input  logic [SRC_W-1:0] last_grant,
   output logic [SRC_W-1:0] grant,
   output logic             any_req
);

   logic [SRC_W:0]   sum;
   logic [SRC_W-1:0] cand;

   // Walk last_grant+1 .. last_grant (mod N_SRC); the first requester wins.
   always_comb begin
      grant   = '0;
      any_req = 1'b0;
      sum     = '0;
      cand    = '0;
      for (int k = 1; k <= N_SRC; k++) begin
         sum = {1'b0, last_grant} + (SRC_W+1)'(k);
         if (sum >= (SRC_W+1)'(N_SRC)) begin
            sum = sum - (SRC_W+1)'(N_SRC);
         end
         cand = sum[SRC_W-1:0];
         if (!any_req && req[cand]) begin
            any_req = 1'b1;
            grant   = cand;
         end
      end
   end

endmodule

// File: rtl/sci_fifo_readout_arb.sv
// rtl/sci_fifo_readout_arb.sv - drains fixed-length packets from N byte FIFOs onto one stream
module sci_fifo_readout_arb
   import sci_readout_pkg::*;
#(
   parameter int N_SRC   = 4,
   parameter int SRC_W   = 2,
   parameter int PKT_LEN = PKT_LEN_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [N_SRC-1:0]        src_en_in,
   input  logic [N_SRC-1:0]        fifo_empty_in,
   input  logic [BYTE_W*N_SRC-1:0] fifo_data_in,
   output logic [N_SRC-1:0]        fifo_rd_out,
   output logic [BYTE_W-1:0]       out_data,
   output logic                    out_valid,
   input  logic                    out_ready_in,
   output logic                    out_sop,
   output logic                    out_eop,
   output logic [SRC_W-1:0]        out_src,
   output logic [PKT_CNT_W-1:0]    pkt_cnt_out,
   output logic                    timeout_err_out,
   output logic                    busy_out
);

   localparam int BC_W = $clog2(PKT_LEN);
   localparam int WC_W = $clog2(TIMEOUT + 1);

   state_t                 state, state_nxt;
   logic [SRC_W-1:0]       grant, grant_nxt;
   logic [SRC_W-1:0]       last_grant, last_grant_nxt;
   logic [BC_W-1:0]        byte_cnt, byte_cnt_nxt;
   logic [WC_W-1:0]        wait_cnt, wait_cnt_nxt;
   logic [PKT_CNT_W-1:0]   pkt_cnt, pkt_cnt_nxt;
   logic [BYTE_W-1:0]      data_q, data_nxt;
   logic                   valid_q, valid_nxt;
   logic                   sop_q, sop_nxt;
   logic                   eop_q, eop_nxt;
   logic [SRC_W-1:0]       src_q, src_nxt;
   logic                   tmo_q, tmo_nxt;
   logic [N_SRC-1:0]       rd_vec;
   logic [SRC_W-1:0]       arb_grant;
   logic                   arb_any;
   logic                   last_byte;

   rr_arbiter #(
      .N_SRC (N_SRC),
      .SRC_W (SRC_W)
   ) u_arb (
      .req        (src_en_in & ~fifo_empty_in),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .any_req    (arb_any)
   );

   assign last_byte = (byte_cnt == BC_W'(PKT_LEN - 1));

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= SRC_W'(N_SRC - 1);
         byte_cnt   <= '0;
         wait_cnt   <= '0;
         pkt_cnt    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         src_q      <= '0;
         tmo_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
         byte_cnt   <= byte_cnt_nxt;
         wait_cnt   <= wait_cnt_nxt;
         pkt_cnt    <= pkt_cnt_nxt;
         data_q     <= data_nxt;
         valid_q    <= valid_nxt;
         sop_q      <= sop_nxt;
         eop_q      <= eop_nxt;
         src_q      <= src_nxt;
         tmo_q      <= tmo_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      byte_cnt_nxt   = byte_cnt;
      wait_cnt_nxt   = wait_cnt;
      pkt_cnt_nxt    = pkt_cnt;
      data_nxt       = data_q;
      valid_nxt      = valid_q;
      sop_nxt        = sop_q;
      eop_nxt        = eop_q;
      src_nxt        = src_q;
      tmo_nxt        = 1'b0;
      rd_vec         = '0;
      case (state)
         IDLE: begin
            if (arb_any) begin
               grant_nxt    = arb_grant;
               byte_cnt_nxt = '0;
               wait_cnt_nxt = '0;
               state_nxt    = READ;
            end
         end
         READ: begin
            // A starved source gives up its turn so the others keep draining.
            if (!fifo_empty_in[grant]) begin
               rd_vec[grant] = 1'b1;
               wait_cnt_nxt  = '0;
               state_nxt     = CAPTURE;
            end else if (wait_cnt == WC_W'(TIMEOUT)) begin
               tmo_nxt        = 1'b1;
               last_grant_nxt = grant;
               wait_cnt_nxt   = '0;
               state_nxt      = IDLE;
            end else begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         CAPTURE: begin
            data_nxt  = fifo_data_in[int'(grant)*BYTE_W +: BYTE_W];
            valid_nxt = 1'b1;
            sop_nxt   = (byte_cnt == '0);
            eop_nxt   = last_byte;
            src_nxt   = grant;
            state_nxt = SEND;
         end
         SEND: begin
            if (out_ready_in) begin
               valid_nxt = 1'b0;
               if (last_byte) begin
                  state_nxt = DONE;
               end else begin
                  byte_cnt_nxt = byte_cnt + 1'b1;
                  state_nxt    = READ;
               end
            end
         end
         DONE: begin
            pkt_cnt_nxt    = pkt_cnt + 1'b1;
            last_grant_nxt = grant;
            state_nxt      = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign fifo_rd_out     = rd_vec;
   assign out_data        = data_q;
   assign out_valid       = valid_q;
   assign out_sop         = sop_q;
   assign out_eop         = eop_q;
   assign out_src         = src_q;
   assign pkt_cnt_out     = pkt_cnt;
   assign timeout_err_out = tmo_q;
   assign busy_out        = (state != IDLE);

endmodule

// File: tb/tb_sci_fifo_readout_arb.sv
// tb/tb_sci_fifo_readout_arb.sv - scoreboard bench with FIFO models and a queue-level reference
module tb_sci_fifo_readout_arb;

   localparam int N   = 4;
   localparam int PL  = 20;
   localparam int TMO = 255;

   logic        clk = 1'b0;
   logic        rst_in;
   logic [3:0]  src_en_in;
   logic [3:0]  fifo_empty_in;
   logic [31:0] fifo_data_in;
   logic [3:0]  fifo_rd_out;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready_in;
   logic        out_sop;
   logic        out_eop;
   logic [1:0]  out_src;
   logic [15:0] pkt_cnt_out;
   logic        timeout_err_out;
   logic        busy_out;

   typedef struct packed {
      logic [7:0] data;
      logic       sop;
      logic       eop;
      logic [1:0] src;
   } beat_t;

   beat_t      exp_q[$];
   logic [7:0] fq[N][$];
   logic [7:0] mq[N][$];
   logic [7:0] dout[N];
   logic [3:0] pend;

   int checks = 0, passes = 0;
   int cyc = 0, hs_count = 0, last_hs_cyc = 0;
   int hs_cyc[$];
   int to_count = 0, to_delta = 0;
   int mpk = 0, mto = 0, mlg = N - 1;
   bit man = 1'b1, man_val = 1'b1;
   int ready_prob = 100;

   sci_fifo_readout_arb dut (
      .clk_in          (clk),
      .rst_in          (rst_in),
      .src_en_in       (src_en_in),
      .fifo_empty_in   (fifo_empty_in),
      .fifo_data_in    (fifo_data_in),
      .fifo_rd_out     (fifo_rd_out),
      .out_data        (out_data),
      .out_valid       (out_valid),
      .out_ready_in    (out_ready_in),
      .out_sop         (out_sop),
      .out_eop         (out_eop),
      .out_src         (out_src),
      .pkt_cnt_out     (pkt_cnt_out),
      .timeout_err_out (timeout_err_out),
      .busy_out        (busy_out)
   );

   assign fifo_data_in = {dout[3], dout[2], dout[1], dout[0]};

   initial forever #10 clk = ~clk;

   initial begin
      #(20 * 90000);
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
   endtask

   // Single-clock FIFO models: a read seen during a cycle pops at the next edge.
   initial begin
      fifo_empty_in = 4'hF;
      for (int i = 0; i < N; i++) dout[i] = 8'h00;
      forever begin
         @(negedge clk);
         pend = fifo_rd_out;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (pend[i] && fq[i].size() > 0) dout[i] = fq[i].pop_front();
            fifo_empty_in[i] = (fq[i].size() == 0);
         end
      end
   end

   initial begin
      out_ready_in = 1'b0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         out_ready_in = man ? man_val : ($urandom_range(0, 99) < 32'(ready_prob));
      end
   end

   initial begin
      beat_t got, e;
      forever begin
         @(negedge clk);
         if (!rst_in) begin
            if (out_valid && out_ready_in) begin
               got = '{data: out_data, sop: out_sop, eop: out_eop, src: out_src};
               if (exp_q.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_beat: got data 0x%0h src %0d, expected no beat", out_data, out_src);
               end else begin
                  e = exp_q.pop_front();
                  check("beat{data,sop,eop,src}", 32'(got), 32'(e));
               end
               hs_count++;
               hs_cyc.push_back(cyc);
               last_hs_cyc = cyc;
            end
            if (timeout_err_out) begin
               to_count++;
               to_delta = cyc - last_hs_cyc;
            end
            if (fifo_rd_out != 4'h0)
               check("rd_onehot_nonempty",
                     32'($onehot(fifo_rd_out) && ((fifo_rd_out & fifo_empty_in) == 4'h0)), 32'd1);
         end
      end
   end

   // Reference: one grant = first enabled non-empty source after the last one;
   // it yields a full packet if enough bytes exist, else a partial with no EOP.
   function automatic bit model_one(input logic [3:0] mask);
      int  s = -1;
      int  n;
      bit  full;
      beat_t e;
      for (int k = 1; k <= N; k++) begin
         int c = (mlg + k) % N;
         if (s < 0 && mask[c] && mq[c].size() > 0) s = c;
      end
      if (s < 0) return 1'b0;
      full = (mq[s].size() >= PL);
      n    = full ? PL : mq[s].size();
      for (int b = 0; b < n; b++) begin
         e.data = mq[s].pop_front();
         e.sop  = (b == 0);
         e.eop  = full && (b == PL - 1);
         e.src  = 2'(s);
         exp_q.push_back(e);
      end
      if (full) mpk++;
      else mto++;
      mlg = s;
      return 1'b1;
   endfunction

   task automatic drain(input logic [3:0] mask);
      while (model_one(mask)) begin end
   endtask

   task automatic load(input int s, input int n, input bit incr);
      for (int b = 0; b < n; b++) begin
         logic [7:0] v;
         v = incr ? 8'(b) : 8'($urandom);
         fq[s].push_back(v);
         mq[s].push_back(v);
      end
   endtask

   task automatic arm(input logic [3:0] mask);
      repeat (2) @(negedge clk);
      src_en_in = mask;
   endtask

   task automatic wait_quiet(input string name);
      int idle = 0;
      for (int i = 0; i < 20000 && idle < 4; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy_out) idle++;
         else idle = 0;
      end
      if (idle < 4) begin
         checks++;
         $display("FAIL %s_drain: %0d beats still expected, busy=%0d", name, exp_q.size(), busy_out);
         exp_q.delete();
      end
   endtask

   task automatic wait_hs(input int target, input string name);
      int i = 0;
      while (hs_count < target && i < 2000) begin
         @(negedge clk);
         i++;
      end
      if (hs_count < target) begin
         checks++;
         $display("FAIL %s_wait: handshakes %0d required %0d", name, hs_count, target);
      end
   endtask

   task automatic wait_sop_valid(input string name);
      int i = 0;
      while (!(out_valid && (out_sop || name == "stall")) && i < 2000) begin
         @(negedge clk);
         i++;
      end
      if (i >= 2000) begin
         checks++;
         $display("FAIL %s_wait: out_valid %0d out_sop %0d", name, out_valid, out_sop);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_rd"}, 32'(fifo_rd_out), 32'd0);
      check({tag, "_pkt_cnt"}, 32'(pkt_cnt_out), 32'd0);
      check({tag, "_busy"}, 32'(busy_out), 32'd0);
      check({tag, "_misc"}, 32'({out_data, out_sop, out_eop, out_src, timeout_err_out}), 32'd0);
   endtask

   initial begin
      int base;
      int to_base;
      logic [7:0] hold;
      logic [3:0] m;

      rst_in    = 1'b1;
      src_en_in = 4'h0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_in = 1'b0;

      // Single source, incrementing payload, full-rate sink.
      load(0, PL, 1'b1);
      arm(4'b0001);
      drain(4'b0001);
      base = hs_cyc.size();
      wait_quiet("single");
      if (hs_cyc.size() >= base + PL) begin
         for (int i = 1; i < PL; i++)
            check("byte_spacing", 32'(hs_cyc[base+i] - hs_cyc[base+i-1]), 32'd3);
      end else begin
         checks++;
         $display("FAIL single_beats: got %0d beats required %0d", hs_cyc.size() - base, PL);
      end
      check("single_pkt_cnt", 32'(pkt_cnt_out), 32'(mpk));

      // Contention across three sources, two packets each.
      src_en_in = 4'h0;
      load(0, 2 * PL, 1'b0);
      load(1, 2 * PL, 1'b0);
      load(3, 2 * PL, 1'b0);
      arm(4'hF);
      drain(4'hF);
      wait_quiet("contention");
      check("contention_pkt_cnt", 32'(pkt_cnt_out), 32'(mpk));

      // Backpressure: stall the sink for 10 cycles after byte 5.
      src_en_in = 4'h0;
      load(2, PL, 1'b0);
      arm(4'hF);
      drain(4'hF);
      base = hs_count;
      wait_hs(base + 5, "stall");
      man_val = 1'b0;
      @(negedge clk);
      wait_sop_valid("stall");
      hold = out_data;
      repeat (10) begin
         @(negedge clk);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_data", 32'(out_data), 32'(hold));
         check("stall_no_rd", 32'(fifo_rd_out), 32'd0);
      end
      man_val = 1'b1;
      wait_quiet("stall");
      check("stall_pkt_cnt", 32'(pkt_cnt_out), 32'(mpk));

      // Underrun: src2 holds only 7 bytes.
      src_en_in = 4'h0;
      load(2, 7, 1'b0);
      load(3, 2 * PL, 1'b0);
      to_base = to_count;
      arm(4'hF);
      drain(4'hF);
      wait_quiet("underrun");
      check("underrun_timeouts", 32'(to_count - to_base), 32'd1);
      check("underrun_latency_ok", 32'(to_delta >= TMO && to_delta <= TMO + 3), 32'd1);
      check("underrun_pkt_cnt", 32'(pkt_cnt_out), 32'(mpk));

      // Mask: src1 disabled; src0 disabled mid-packet still completes.
      src_en_in = 4'h0;
      load(1, PL, 1'b0);
      load(0, 2 * PL, 1'b0);
      arm(4'b0001);
      void'(model_one(4'b0001));
      wait_sop_valid("mask");
      src_en_in = 4'b0000;
      wait_quiet("mask");
      check("mask_pkt_cnt", 32'(pkt_cnt_out), 32'(mpk));
      check("mask_src1_untouched", 32'(fq[1].size()), 32'(PL));
      check("mask_src0_left", 32'(fq[0].size()), 32'(PL));
      src_en_in = 4'hF;
      drain(4'hF);
      wait_quiet("mask_release");
      check("mask_release_pkt_cnt", 32'(pkt_cnt_out), 32'(mpk));

      // Randomized scenarios with random sink throttling.
      for (int sc = 0; sc < 6; sc++) begin
         src_en_in  = 4'h0;
         man        = 1'b0;
         ready_prob = $urandom_range(30, 100);
         for (int s = 0; s < N; s++)
            load(s, $urandom_range(0, 2) * PL + (($urandom_range(0, 5) == 0) ? $urandom_range(1, PL - 1) : 0), 1'b0);
         m = 4'($urandom_range(1, 15));
         arm(m);
         drain(m);
         wait_quiet("random");
         check("random_pkt_cnt", 32'(pkt_cnt_out), 32'(mpk));
         check("random_timeouts", 32'(to_count), 32'(mto));
      end
      man     = 1'b1;
      man_val = 1'b1;
      src_en_in = 4'hF;
      drain(4'hF);
      wait_quiet("flush");
      check("flush_timeouts", 32'(to_count), 32'(mto));

      // Reset in the middle of a packet, then restart with src0 and src1 pending.
      src_en_in = 4'h0;
      load(0, PL, 1'b1);
      arm(4'b0001);
      drain(4'b0001);
      base = hs_count;
      wait_hs(base + 10, "midreset");
      rst_in = 1'b1;
      @(negedge clk);
      check_reset_outputs("midreset");
      exp_q.delete();
      for (int s = 0; s < N; s++) begin
         fq[s].delete();
         mq[s].delete();
      end
      mpk = 0;
      mlg = N - 1;
      src_en_in = 4'h0;
      load(1, PL, 1'b0);
      load(0, PL, 1'b0);
      repeat (2) @(negedge clk);
      rst_in = 1'b0;
      @(negedge clk);
      src_en_in = 4'b0011;
      drain(4'b0011);
      wait_sop_valid("restart");
      check("restart_first_src", 32'(out_src), 32'd0);
      check("restart_pkt_cnt_before_done", 32'(pkt_cnt_out), 32'd0);
      wait_quiet("restart");
      check("restart_pkt_cnt", 32'(pkt_cnt_out), 32'(mpk));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
